// File: rtl/lieat_exu_vpu_vcfg_sched_pkg.sv
// Shared types and constants for the VPU vl/vtype configuration sequencer.
package lieat_exu_vpu_vcfg_sched_pkg;

    localparam int XLEN        = 32;
    localparam int VL_W        = 5;
    localparam int VEC_MAX_DEF = 4;
    localparam int CNT_W_DEF   = 3;

    // Sequencer state encoding (2-bit)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_VEC   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_VSET  = 2'b11
    } vcfg_state_e;

endpackage

// File: rtl/lieat_exu_vpu_vcfg_cnt.sv
// Saturating up/down counter of vector ops in flight (issued, not yet retired).
module lieat_exu_vpu_vcfg_cnt #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         inc_s;
    logic         dec_s;

    assign full  = (cnt_q == W'(MAX));
    assign empty = (cnt_q == {W{1'b0}});
    assign cnt   = cnt_q;

    // A retire with nothing in flight is dropped; an issue when full cannot happen.
    assign inc_s = inc & ~full;
    assign dec_s = dec & ~empty;

    // Next count: clear dominates, simultaneous issue and retire cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else begin
            case ({inc_s, dec_s})
                2'b10:   cnt_d = cnt_q + W'(1);
                2'b01:   cnt_d = cnt_q - W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lieat_exu_vpu_vcfg_sched.sv
// Sequencer between VPU dispatch and the vset unit / vector datapath. Holds the
// architectural vl/vtype and keeps vector ops from issuing under a stale config.
module lieat_exu_vpu_vcfg_sched
    import lieat_exu_vpu_vcfg_sched_pkg::*;
#(
    parameter int VEC_MAX = VEC_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_req,
    input  logic            disp_i_valid,
    output logic            disp_i_ready,
    input  logic            disp_i_is_vset,
    output logic            vset_o_valid,
    input  logic            vset_o_ready,
    output logic            vec_o_valid,
    input  logic            vec_o_ready,
    input  logic            vec_done,
    input  logic            wb_vcfg_wen,
    input  logic [VL_W-1:0] wb_vl_wdata,
    input  logic [XLEN-1:0] wb_vtype_wdata,
    output logic [VL_W-1:0] vl_rdata,
    output logic [XLEN-1:0] vtype_rdata,
    output logic            busy
);

    vcfg_state_e     state_q;
    vcfg_state_e     state_d;
    logic [VL_W-1:0] vl_q;
    logic [VL_W-1:0] vl_d;
    logic [XLEN-1:0] vtype_q;
    logic [XLEN-1:0] vtype_d;

    logic             vset_offer_s;
    logic             vec_offer_s;
    logic             vset_valid_s;
    logic             vec_valid_s;
    logic             vec_fire_s;
    logic             vset_fire_s;
    logic             cfg_wen_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_full_s;
    logic             cnt_empty_s;

    assign vset_offer_s = disp_i_valid & disp_i_is_vset;
    assign vec_offer_s  = disp_i_valid & ~disp_i_is_vset;
    assign vset_fire_s  = vset_valid_s & vset_o_ready;
    assign vec_fire_s   = vec_valid_s & vec_o_ready;

    lieat_exu_vpu_vcfg_cnt #(
        .MAX (VEC_MAX),
        .W   (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (vec_fire_s),
        .dec   (vec_done),
        .clr   (flush_req),
        .cnt   (cnt_s),
        .full  (cnt_full_s),
        .empty (cnt_empty_s)
    );

    // Next-state and issue gating; flush or reset kills any issue this cycle.
    always_comb begin
        state_d      = state_q;
        vset_valid_s = 1'b0;
        vec_valid_s  = 1'b0;
        cfg_wen_s    = 1'b0;
        if (flush_req || !reset) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vset_offer_s) begin
                        vset_valid_s = 1'b1;
                        state_d      = vset_o_ready ? ST_VSET : ST_IDLE;
                    end else if (vec_offer_s && !cnt_full_s) begin
                        vec_valid_s = 1'b1;
                        state_d     = vec_o_ready ? ST_VEC : ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_VEC: begin
                    if (vset_offer_s) begin
                        // The vset must wait until every older vector op retires.
                        state_d = ST_DRAIN;
                    end else begin
                        vec_valid_s = vec_offer_s & ~cnt_full_s;
                        if (cnt_empty_s || ((cnt_s == CNT_W'(1)) && vec_done && !(vec_valid_s && vec_o_ready))) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_VEC;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (vset_offer_s && cnt_empty_s) begin
                        vset_valid_s = 1'b1;
                        state_d      = vset_o_ready ? ST_VSET : ST_DRAIN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_VSET: begin
                    if (wb_vcfg_wen) begin
                        cfg_wen_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_VSET;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // New vl/vtype is taken only from a writeback that lands while waiting in VSET.
    always_comb begin
        if (cfg_wen_s) begin
            vl_d    = wb_vl_wdata;
            vtype_d = wb_vtype_wdata;
        end else begin
            vl_d    = vl_q;
            vtype_d = vtype_q;
        end
    end

    // State and vl/vtype registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            vl_q    <= {VL_W{1'b0}};
            vtype_q <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            vl_q    <= vl_d;
            vtype_q <= vtype_d;
        end
    end

    assign vset_o_valid = vset_valid_s;
    assign vec_o_valid  = vec_valid_s;
    assign disp_i_ready = vset_fire_s | vec_fire_s;
    assign vl_rdata     = vl_q;
    assign vtype_rdata  = vtype_q;
    assign busy         = (state_q != ST_IDLE) | ~cnt_empty_s;

endmodule

// File: tb/tb_lieat_exu_vpu_vcfg_sched.sv
// Directed self-checking bench for the VPU vl/vtype configuration sequencer.
module tb_lieat_exu_vpu_vcfg_sched;

    logic        clock;
    logic        reset;
    logic        flush_req;
    logic        disp_i_valid;
    logic        disp_i_ready;
    logic        disp_i_is_vset;
    logic        vset_o_valid;
    logic        vset_o_ready;
    logic        vec_o_valid;
    logic        vec_o_ready;
    logic        vec_done;
    logic        wb_vcfg_wen;
    logic [4:0]  wb_vl_wdata;
    logic [31:0] wb_vtype_wdata;
    logic [4:0]  vl_rdata;
    logic [31:0] vtype_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_VEC   = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_VSET  = 2'b11;

    lieat_exu_vpu_vcfg_sched dut (
        .clock          (clock),
        .reset          (reset),
        .flush_req      (flush_req),
        .disp_i_valid   (disp_i_valid),
        .disp_i_ready   (disp_i_ready),
        .disp_i_is_vset (disp_i_is_vset),
        .vset_o_valid   (vset_o_valid),
        .vset_o_ready   (vset_o_ready),
        .vec_o_valid    (vec_o_valid),
        .vec_o_ready    (vec_o_ready),
        .vec_done       (vec_done),
        .wb_vcfg_wen    (wb_vcfg_wen),
        .wb_vl_wdata    (wb_vl_wdata),
        .wb_vtype_wdata (wb_vtype_wdata),
        .vl_rdata       (vl_rdata),
        .vtype_rdata    (vtype_rdata),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        flush_req      = 1'b0;
        disp_i_valid   = 1'b1;
        disp_i_is_vset = 1'b1;
        vset_o_ready   = 1'b1;
        vec_o_ready    = 1'b1;
        vec_done       = 1'b0;
        wb_vcfg_wen    = 1'b0;
        wb_vl_wdata    = 5'h00;
        wb_vtype_wdata = 32'h0000_0000;

        // Reset state, dispatch offering a vset during reset
        #12;
        chk("rst_vset_valid", {31'd0, vset_o_valid}, 32'd0);
        chk("rst_disp_ready", {31'd0, disp_i_ready}, 32'd0);
        chk("rst_vl",         {27'd0, vl_rdata},     32'd0);
        chk("rst_vtype",      vtype_rdata,           32'd0);
        chk("rst_busy",       {31'd0, busy},         32'd0);
        disp_i_valid = 1'b0;
        reset = 1'b1;
        tick();

        // 1: vset issue and writeback
        disp_i_valid = 1'b1; disp_i_is_vset = 1'b1;
        #2;
        chk("t1_vset_valid", {31'd0, vset_o_valid}, 32'd1);
        chk("t1_disp_ready", {31'd0, disp_i_ready}, 32'd1);
        chk("t1_vec_valid",  {31'd0, vec_o_valid},  32'd0);
        tick();
        chk("t1_state_vset", {30'd0, dut.state_q},  {30'd0, S_VSET});
        chk("t1_busy",       {31'd0, busy},         32'd1);
        disp_i_is_vset = 1'b0;
        wb_vcfg_wen = 1'b1; wb_vl_wdata = 5'h07; wb_vtype_wdata = 32'h0000_0048;
        #2;
        chk("t1_vset_stall", {31'd0, vec_o_valid},  32'd0);
        chk("t1_vset_nrdy",  {31'd0, disp_i_ready}, 32'd0);
        tick();
        wb_vcfg_wen = 1'b0;
        chk("t1_vl",    {27'd0, vl_rdata}, 32'h07);
        chk("t1_vtype", vtype_rdata,       32'h48);
        chk("t1_idle",  {30'd0, dut.state_q}, {30'd0, S_IDLE});
        #2;
        chk("t1_vec_after_wb", {31'd0, vec_o_valid}, 32'd1);

        // 2: five back-to-back vec ops, only four may be in flight
        tick();
        chk("t2_cnt1", {29'd0, dut.cnt_s}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_fire", {31'd0, disp_i_ready}, 32'd1);
            tick();
        end
        chk("t2_cnt4", {29'd0, dut.cnt_s}, 32'd4);
        chk("t2_full_stall", {31'd0, disp_i_ready}, 32'd0);
        tick();
        chk("t2_still_stall", {31'd0, vec_o_valid}, 32'd0);
        vec_done = 1'b1;
        #2;
        chk("t2_done_stall", {31'd0, disp_i_ready}, 32'd0);
        tick();
        vec_done = 1'b0;
        chk("t2_cnt3", {29'd0, dut.cnt_s}, 32'd3);
        chk("t2_5th_fire", {31'd0, disp_i_ready}, 32'd1);
        tick();
        disp_i_valid = 1'b0;
        chk("t2_cnt4b", {29'd0, dut.cnt_s}, 32'd4);

        // 4a: drain to 2, then issue and retire in the same cycle
        vec_done = 1'b1;
        tick();
        tick();
        chk("t4_cnt2", {29'd0, dut.cnt_s}, 32'd2);
        disp_i_valid = 1'b1; disp_i_is_vset = 1'b0;
        #2;
        chk("t4_fire_and_done", {31'd0, disp_i_ready}, 32'd1);
        tick();
        vec_done = 1'b0;
        chk("t4_cnt_hold", {29'd0, dut.cnt_s}, 32'd2);

        // 3: vset behind two in-flight vec ops drains first
        disp_i_is_vset = 1'b1;
        #2;
        chk("t3_vset_held", {31'd0, vset_o_valid}, 32'd0);
        tick();
        chk("t3_drain", {30'd0, dut.state_q}, {30'd0, S_DRAIN});
        vec_done = 1'b1;
        tick();
        chk("t3_cnt1_no_vset", {31'd0, vset_o_valid}, 32'd0);
        tick();
        vec_done = 1'b0;
        chk("t3_cnt0_vset", {31'd0, vset_o_valid}, 32'd1);
        tick();
        chk("t3_state_vset", {30'd0, dut.state_q}, {30'd0, S_VSET});
        disp_i_is_vset = 1'b0;
        #2;
        chk("t3_vec_wait", {31'd0, vec_o_valid}, 32'd0);
        tick();
        wb_vcfg_wen = 1'b1; wb_vl_wdata = 5'h10; wb_vtype_wdata = 32'h0000_00c1;
        #2;
        chk("t3_vec_wait_wen", {31'd0, vec_o_valid}, 32'd0);
        tick();
        wb_vcfg_wen = 1'b0;
        chk("t3_vl",    {27'd0, vl_rdata}, 32'h10);
        chk("t3_vtype", vtype_rdata,       32'hc1);
        #2;
        chk("t3_vec_go", {31'd0, vec_o_valid}, 32'd1);
        tick();
        disp_i_valid = 1'b0;

        // 4b: retire back to empty, then an extra retire is ignored
        vec_done = 1'b1;
        tick();
        chk("t4_idle", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        chk("t4_not_busy", {31'd0, busy}, 32'd0);
        tick();
        vec_done = 1'b0;
        chk("t4_no_underflow", {29'd0, dut.cnt_s}, 32'd0);

        // 5a: flush with a writeback in VSET drops the writeback
        disp_i_valid = 1'b1; disp_i_is_vset = 1'b1;
        tick();
        disp_i_valid = 1'b0;
        chk("t5_state_vset", {30'd0, dut.state_q}, {30'd0, S_VSET});
        flush_req = 1'b1; wb_vcfg_wen = 1'b1; wb_vl_wdata = 5'h03; wb_vtype_wdata = 32'h0000_0099;
        tick();
        flush_req = 1'b0; wb_vcfg_wen = 1'b0;
        chk("t5_flush_idle",  {30'd0, dut.state_q}, {30'd0, S_IDLE});
        chk("t5_vl_kept",     {27'd0, vl_rdata},    32'h10);
        chk("t5_vtype_kept",  vtype_rdata,          32'hc1);

        // 5b: flush in VEC with three ops in flight
        disp_i_valid = 1'b1; disp_i_is_vset = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_cnt3", {29'd0, dut.cnt_s}, 32'd3);
        flush_req = 1'b1;
        #2;
        chk("t5_flush_no_issue", {31'd0, vec_o_valid},  32'd0);
        chk("t5_flush_no_ready", {31'd0, disp_i_ready}, 32'd0);
        tick();
        flush_req = 1'b0; disp_i_valid = 1'b0;
        chk("t5_flush_cnt0", {29'd0, dut.cnt_s}, 32'd0);
        chk("t5_flush_idle2", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        chk("t5_flush_busy", {31'd0, busy}, 32'd0);
        vec_done = 1'b1;
        tick();
        vec_done = 1'b0;
        chk("t5_late_done", {29'd0, dut.cnt_s}, 32'd0);

        // 6: asynchronous reset while in DRAIN
        disp_i_valid = 1'b1; disp_i_is_vset = 1'b0;
        tick();
        disp_i_is_vset = 1'b1;
        tick();
        chk("t6_drain", {30'd0, dut.state_q}, {30'd0, S_DRAIN});
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        chk("t6_rst_cnt",   {29'd0, dut.cnt_s},   32'd0);
        chk("t6_rst_vl",    {27'd0, vl_rdata},    32'd0);
        chk("t6_rst_vtype", vtype_rdata,          32'd0);
        chk("t6_rst_busy",  {31'd0, busy},        32'd0);
        chk("t6_rst_vset",  {31'd0, vset_o_valid}, 32'd0);
        chk("t6_rst_ready", {31'd0, disp_i_ready}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_resume_vset", {31'd0, vset_o_valid}, 32'd1);
        tick();
        disp_i_valid = 1'b0;
        chk("t6_resume_state", {30'd0, dut.state_q}, {30'd0, S_VSET});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
